// File: rtl/key_event_gen.sv
// Push-button front end: synchronise, debounce and turn each active-low key
// into press/release pulses, a held level and a one-shot long-press pulse.
module key_event_gen #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000
) (
  input  logic                CLOCK_50,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] KEY,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic [NUM_KEYS-1:0] held,
  output logic [NUM_KEYS-1:0] long_pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_CYCLES + 1);

  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [DW-1:0] deb_cnt;
    logic [HW-1:0] hold_cnt;
    logic          long_done;
    logic          held_q;
    logic          press_q;
    logic          release_q;
    logic          long_q;

    // NOTE: every register here uses <= so all keys see pre-edge values;
    // held_q is read below as last cycle's ~stable to form the edge pulses.
    always_ff @(posedge CLOCK_50) begin
      if (!reset_n) begin
        sync1     <= 1'b1;
        sync2     <= 1'b1;
        stable    <= 1'b1;
        deb_cnt   <= '0;
        hold_cnt  <= '0;
        long_done <= 1'b0;
        held_q    <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
      end else begin
        sync1 <= KEY[g];
        sync2 <= sync1;

        // Any cycle agreeing with the accepted level restarts the count.
        if (sync2 == stable) begin
          deb_cnt <= '0;
        end else if (deb_cnt == DEB_LAST) begin
          stable  <= sync2;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + DW'(1);
        end

        held_q    <= ~stable;
        press_q   <= ~stable & ~held_q;
        release_q <= stable & held_q;

        if (stable) begin
          hold_cnt <= '0;
        end else if (hold_cnt != HOLD_MAX) begin
          hold_cnt <= hold_cnt + HW'(1);
        end

        // One long pulse per press; re-armed only by an accepted release.
        long_q <= 1'b0;
        if (!stable && hold_cnt == HOLD_MAX && !long_done) begin
          long_q    <= 1'b1;
          long_done <= 1'b1;
        end else if (stable && held_q) begin
          long_done <= 1'b0;
        end
      end
    end

    assign press_pulse[g]   = press_q;
    assign release_pulse[g] = release_q;
    assign held[g]          = held_q;
    assign long_pulse[g]    = long_q;
  end

endmodule

// File: tb/tb_key_event_gen.sv
// Directed bench for key_event_gen: expected per-cycle outputs are queued as
// stimulus is applied and compared one entry per clock edge.
module tb_key_event_gen;

  localparam int N = 4;

  logic         CLOCK_50 = 1'b0;
  logic         reset_n;
  logic [N-1:0] KEY;
  logic [N-1:0] press_pulse;
  logic [N-1:0] release_pulse;
  logic [N-1:0] held;
  logic [N-1:0] long_pulse;

  key_event_gen #(
    .NUM_KEYS        (N),
    .DEBOUNCE_CYCLES (4),
    .LONG_CYCLES     (10)
  ) dut (
    .CLOCK_50      (CLOCK_50),
    .reset_n       (reset_n),
    .KEY           (KEY),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .held          (held),
    .long_pulse    (long_pulse)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct packed {
    logic [N-1:0] p;
    logic [N-1:0] r;
    logic [N-1:0] h;
    logic [N-1:0] l;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cycle    = 0;
  string scen    = "reset";

  localparam logic [N-1:0] Z = '0;

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic expect_n(input int n, input logic [N-1:0] p, input logic [N-1:0] r,
                          input logic [N-1:0] h, input logic [N-1:0] l);
    exp_t e;
    e = '{p: p, r: r, h: h, l: l};
    repeat (n) q.push_back(e);
  endtask

  // One clock edge; sample 1 time unit later and compare the oldest entry.
  task automatic step();
    exp_t e;
    @(posedge CLOCK_50);
    #1;
    cycle++;
    e = q.pop_front();
    check($sformatf("%s.press@%0d", scen, cycle),   press_pulse,   e.p);
    check($sformatf("%s.release@%0d", scen, cycle), release_pulse, e.r);
    check($sformatf("%s.held@%0d", scen, cycle),    held,          e.h);
    check($sformatf("%s.long@%0d", scen, cycle),    long_pulse,    e.l);
  endtask

  task automatic drain();
    while (q.size() > 0) step();
  endtask

  initial begin
    logic [6:0] bounce;

    KEY     = '1;
    reset_n = 1'b0;
    repeat (2) @(posedge CLOCK_50);
    #1;
    check("reset.press",   press_pulse,   Z);
    check("reset.release", release_pulse, Z);
    check("reset.held",    held,          Z);
    check("reset.long",    long_pulse,    Z);
    reset_n = 1'b1;
    expect_n(3, Z, Z, Z, Z);
    drain();

    // Clean press on key 0: pulse in the cycle after edge 7.
    scen = "press0"; cycle = 0;
    KEY[0] = 1'b0;
    expect_n(6, Z, Z, Z, Z);
    expect_n(1, 4'b0001, Z, 4'b0001, Z);
    expect_n(2, Z, Z, 4'b0001, Z);
    drain();

    // Release of key 0 before the long-press threshold.
    scen = "release0"; cycle = 0;
    KEY[0] = 1'b1;
    expect_n(6, Z, Z, 4'b0001, Z);
    expect_n(1, Z, 4'b0001, Z, Z);
    expect_n(3, Z, Z, Z, Z);
    drain();

    // Bounce on key 1: low 3, high 1, low 3, then high -- never accepted.
    scen = "bounce1"; cycle = 0;
    bounce = 7'b1110111;
    for (int i = 6; i >= 0; i--) begin
      KEY[1] = ~bounce[i];
      expect_n(1, Z, Z, Z, Z);
      step();
    end
    KEY[1] = 1'b1;
    expect_n(10, Z, Z, Z, Z);
    drain();

    // Long press on key 2 for 30 cycles: one long pulse 10 edges after press.
    scen = "long2"; cycle = 0;
    KEY[2] = 1'b0;
    expect_n(6,  Z, Z, Z, Z);
    expect_n(1,  4'b0100, Z, 4'b0100, Z);
    expect_n(9,  Z, Z, 4'b0100, Z);
    expect_n(1,  Z, Z, 4'b0100, 4'b0100);
    expect_n(13, Z, Z, 4'b0100, Z);
    drain();
    scen = "long2rel"; cycle = 0;
    KEY[2] = 1'b1;
    expect_n(6, Z, Z, 4'b0100, Z);
    expect_n(1, Z, 4'b0100, Z, Z);
    expect_n(3, Z, Z, Z, Z);
    drain();

    // Keys 0 and 3 together, then reset while both stay held.
    scen = "simul"; cycle = 0;
    KEY = 4'b0110;
    expect_n(6, Z, Z, Z, Z);
    expect_n(1, 4'b1001, Z, 4'b1001, Z);
    expect_n(2, Z, Z, 4'b1001, Z);
    drain();
    scen = "midreset"; cycle = 0;
    reset_n = 1'b0;
    expect_n(1, Z, Z, Z, Z);
    drain();
    reset_n = 1'b1;
    scen = "afterreset"; cycle = 0;
    expect_n(6, Z, Z, Z, Z);
    expect_n(1, 4'b1001, Z, 4'b1001, Z);
    expect_n(2, Z, Z, 4'b1001, Z);
    drain();
    scen = "simulrel"; cycle = 0;
    KEY = '1;
    expect_n(6, Z, Z, 4'b1001, Z);
    expect_n(1, Z, 4'b1001, Z, Z);
    expect_n(3, Z, Z, Z, Z);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_event_gen.md
Name: key_event_gen

Overview:
Upstream input stage for the SDES board controller. It replaces the per-button debounce instances. It synchronises and debounces the active-low push buttons, then converts each one into single-cycle press and release events, a held level, and a one-shot long-press event. The mode/state FSM consumes press_pulse to advance states and long_pulse to trigger reset.

Parameters:
NUM_KEYS, 4, number of independent active-low buttons handled.
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a new level (20 ms at 50 MHz); must be >= 2.
LONG_CYCLES, 50000000, held cycles after press_pulse before long_pulse fires (1 s at 50 MHz); must be > DEBOUNCE_CYCLES.

Ports:
CLOCK_50  input  1  system clock; all logic on rising edge.
reset_n  input  1  synchronous, active-low reset.
KEY  input  NUM_KEYS  raw asynchronous buttons; 0 = pressed.
press_pulse  output  NUM_KEYS  one-cycle high per accepted press.
release_pulse  output  NUM_KEYS  one-cycle high per accepted release.
held  output  NUM_KEYS  high while the debounced key is pressed.
long_pulse  output  NUM_KEYS  one-cycle high once per press held >= LONG_CYCLES.

Behaviour:
- Interface: one clock, CLOCK_50. Reset reset_n is synchronous and active-low.
- Keys are fully independent. Per key, the following state exists:
  - 2-flop synchroniser sync1/sync2;
  - stable level;
  - debounce counter, width $clog2(DEBOUNCE_CYCLES);
  - hold counter, width $clog2(LONG_CYCLES+1);
  - long_done flag.
- Reset (reset_n=0 at an edge):
  - sync1, sync2 and stable are set to 1 (released).
  - All counters are cleared to 0 and long_done is cleared.
  - press_pulse, release_pulse, held and long_pulse are all 0 from the next cycle.
  - Reset takes priority over every other event.
- Debounce counter, evaluated each edge:
  - If sync2 == stable, counter <= 0.
  - Otherwise, if counter == DEBOUNCE_CYCLES-1, then stable <= sync2 and counter <= 0.
  - Otherwise, counter increments.
  - Any agreeing cycle restarts the count, so a glitch shorter than DEBOUNCE_CYCLES is never accepted.
- Latency: number the first edge that samples KEY at its new level as edge 1.
  - sync2 takes the new level at edge 2.
  - stable flips at edge DEBOUNCE_CYCLES+2.
  - The event pulse registers at edge DEBOUNCE_CYCLES+3.
- Event outputs:
  - press_pulse[i] is 1 for exactly one cycle after stable 1->0.
  - release_pulse[i] is 1 for exactly one cycle after stable 0->1.
  - held[i] is registered ~stable, so it rises in the same cycle as press_pulse and falls with release_pulse.
- Hold counter:
  - Cleared while stable = 1.
  - Increments each edge while stable = 0, saturating at LONG_CYCLES.
  - When it reaches LONG_CYCLES with long_done = 0: long_pulse is 1 for one cycle and long_done is set.
  - This places long_pulse exactly LONG_CYCLES edges after press_pulse's edge.
  - No auto-repeat: long_done is cleared only on an accepted release.
- Release before LONG_CYCLES: no long_pulse. The release_pulse is still generated.
- Simultaneous presses on several keys produce pulses in the same cycle on each bit. There is no arbitration.
- Key already held when reset_n deasserts: it is treated as a fresh press after the normal latency.
- Reset asserted during a debounce count or a hold: the operation is abandoned and no pulse is emitted for it.

Test Plan:
- Use DEBOUNCE_CYCLES=4 and LONG_CYCLES=10 for all scenarios.
- Clean press: KEY[0] goes 1->0 and stays low.
  - Required: press_pulse[0]=1 only in the cycle after edge 7.
  - Required: held[0] rises at the same time; other bits stay 0.
- Bounce rejection: KEY[1] is low for 3 cycles, high 1 cycle, low 3 cycles, then high.
  - Required: no press_pulse, held or release_pulse on any bit.
- Release: after scenario 1 is accepted, KEY[0] goes 0->1.
  - Required: release_pulse[0] for one cycle at edge 7 after the change; held[0] falls at the same time.
- Long press: KEY[2] is held low for 30 cycles.
  - Required: exactly one long_pulse[2], 10 edges after the press_pulse edge.
  - Required: no repeat while held; on release, a single release_pulse with no long_pulse.
- Simultaneous keys plus reset:
  - KEY[0] and KEY[3] are pressed in the same cycle. Required: press_pulse = 4'b1001 in a single cycle.
  - Then reset_n=0 for 1 cycle while both are held. Required: all outputs 0 next cycle.
  - After reset, with both keys still held: press_pulse = 4'b1001 again 7 edges later.
